// File: rtl/digit_scan_driver.sv
// Multiplexed hex-digit scanner with a frame-synchronous staging/shadow buffer, registered outputs.
// Optional leading-zero blanking enabled by defining DIGIT_SCAN_LZ_BLANK_EN.
module digit_scan_driver #(
   parameter int NDIG  = 8,
   parameter int DWELL = 100000,
   parameter int GUARD = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [4*NDIG-1:0] value,
   input  logic [NDIG-1:0]   dp,
   input  logic [NDIG-1:0]   digit_en,
   input  logic              load,
   output logic              pending,
   output logic              frame_done,
   output logic [NDIG-1:0]   digitselect,
   output logic [7:0]        segments
);
   localparam int CW = $clog2(DWELL);
   localparam int IW = $clog2(NDIG);

   logic [CW-1:0]     cnt;
   logic [IW-1:0]     idx;
   logic [4*NDIG-1:0] stage_val;
   logic [4*NDIG-1:0] shadow_val;
   logic [NDIG-1:0]   stage_dp;
   logic [NDIG-1:0]   shadow_dp;
   logic              wrap;
   logic              boundary;
   logic [3:0]        nib;
   logic [7:0]        glyph;
   logic              lz_blank;
   logic              lit;

   assign wrap     = (cnt == CW'(DWELL - 1));
   assign boundary = wrap && (idx == IW'(NDIG - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
         idx <= '0;
      end else if (wrap) begin
         cnt <= '0;
         idx <= boundary ? '0 : idx + IW'(1);
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // A load coinciding with the boundary bypasses staging so it still lands in the next frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stage_val  <= '0;
         stage_dp   <= '0;
         shadow_val <= '0;
         shadow_dp  <= '0;
         pending    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= boundary;
         if (load) begin
            stage_val <= value;
            stage_dp  <= dp;
         end
         if (boundary) begin
            pending <= 1'b0;
            if (load) begin
               shadow_val <= value;
               shadow_dp  <= dp;
            end else if (pending) begin
               shadow_val <= stage_val;
               shadow_dp  <= stage_dp;
            end
         end else if (load) begin
            pending <= 1'b1;
         end
      end
   end

`ifdef DIGIT_SCAN_LZ_BLANK_EN
   logic [NDIG-1:0] upper_zero;
   logic            zero_run;

   // upper_zero[i]: nibble i and every nibble above it are zero.
   always_comb begin
      upper_zero = '0;
      zero_run   = 1'b1;
      for (int i = NDIG - 1; i >= 0; i--) begin
         zero_run      = zero_run && (shadow_val[4*i +: 4] == 4'h0);
         upper_zero[i] = zero_run;
      end
      lz_blank = (idx != '0) && upper_zero[idx] && !shadow_dp[idx];
   end
`else
   assign lz_blank = 1'b0;
`endif

   always_comb begin
      nib = shadow_val[{idx, 2'b00} +: 4];
      case (nib)
         4'h0:    glyph = 8'hFC;
         4'h1:    glyph = 8'h60;
         4'h2:    glyph = 8'hDA;
         4'h3:    glyph = 8'hF2;
         4'h4:    glyph = 8'h66;
         4'h5:    glyph = 8'hB6;
         4'h6:    glyph = 8'hBE;
         4'h7:    glyph = 8'hE0;
         4'h8:    glyph = 8'hFE;
         4'h9:    glyph = 8'hF6;
         4'hA:    glyph = 8'hEE;
         4'hB:    glyph = 8'h3E;
         4'hC:    glyph = 8'h1A;
         4'hD:    glyph = 8'h7A;
         4'hE:    glyph = 8'h9E;
         4'hF:    glyph = 8'h8E;
         default: glyph = 8'h01;
      endcase
      lit = (int'(cnt) >= GUARD) && digit_en[idx] && !lz_blank;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         digitselect <= '1;
         segments    <= 8'hFF;
      end else begin
         digitselect <= lit ? ~(NDIG'(1) << idx) : '1;
         segments    <= lit ? ~(glyph | {7'b0, shadow_dp[idx]}) : 8'hFF;
      end
   end
endmodule

// File: tb/tb_digit_scan_driver.sv
// Randomised and directed bench for digit_scan_driver against a frame-level reference model.
module tb_digit_scan_driver;
   localparam int NDIG  = 4;
   localparam int DWELL = 4;
   localparam int GUARD = 1;
   localparam int FRAME = NDIG * DWELL;
   localparam logic [7:0] GLYPH [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                         8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h1A, 8'h7A, 8'h9E, 8'h8E};

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp = '0;
   logic [3:0]  digit_en = 4'hF;
   logic        load = 1'b0;
   logic        pending;
   logic        frame_done;
   logic [3:0]  digitselect;
   logic [7:0]  segments;

   int n_cmp = 0;
   int n_fail = 0;

   // Reference model: scan position since reset, last load seen, frame's displayed value.
   int          pos;
   logic [15:0] latest_val, shadow_val;
   logic [3:0]  latest_dp, shadow_dp;
   bit          frame_loaded;

   always #5 clk = ~clk;

   digit_scan_driver #(.NDIG(NDIG), .DWELL(DWELL), .GUARD(GUARD)) dut (
      .clk(clk), .reset_n(reset_n), .value(value), .dp(dp), .digit_en(digit_en), .load(load),
      .pending(pending), .frame_done(frame_done), .digitselect(digitselect), .segments(segments)
   );

   task automatic model_reset();
      pos = 0;
      latest_val = '0;
      latest_dp = '0;
      shadow_val = '0;
      shadow_dp = '0;
      frame_loaded = 0;
   endtask

   // One clock: drive inputs, advance the model, compare all outputs after the edge.
   task automatic step(input bit ld, input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
      int cnt, dig;
      bit lit, exp_fd, exp_pend;
      logic [3:0] nib, exp_sel;
      logic [7:0] exp_seg;
      load = ld; value = v; dp = d; digit_en = e;
      if (pos % FRAME == 0) begin
         shadow_val = latest_val;
         shadow_dp = latest_dp;
         frame_loaded = 0;
      end
      cnt = pos % DWELL;
      dig = (pos / DWELL) % NDIG;
      nib = shadow_val[dig*4 +: 4];
      lit = (cnt >= GUARD) && e[dig];
`ifdef DIGIT_SCAN_LZ_BLANK_EN
      if (dig > 0 && !shadow_dp[dig] && (shadow_val >> (4*dig)) == 16'h0) lit = 0;
`endif
      exp_sel = lit ? (4'hF ^ (4'b0001 << dig)) : 4'hF;
      exp_seg = lit ? ~(GLYPH[nib] | {7'b0, shadow_dp[dig]}) : 8'hFF;
      if (ld) begin
         latest_val = v;
         latest_dp = d;
         frame_loaded = 1;
      end
      pos++;
      exp_fd = (pos % FRAME == 0);
      exp_pend = exp_fd ? 1'b0 : frame_loaded;
      @(posedge clk);
      #1;
      n_cmp++;
      if (digitselect !== exp_sel) begin
         n_fail++;
         $display("FAIL digitselect pos=%0d got %b want %b", pos - 1, digitselect, exp_sel);
      end
      n_cmp++;
      if (segments !== exp_seg) begin
         n_fail++;
         $display("FAIL segments pos=%0d got %h want %h", pos - 1, segments, exp_seg);
      end
      n_cmp++;
      if (frame_done !== exp_fd) begin
         n_fail++;
         $display("FAIL frame_done pos=%0d got %b want %b", pos - 1, frame_done, exp_fd);
      end
      n_cmp++;
      if (pending !== exp_pend) begin
         n_fail++;
         $display("FAIL pending pos=%0d got %b want %b", pos - 1, pending, exp_pend);
      end
      @(negedge clk);
   endtask

   task automatic run(input int k, input logic [3:0] e);
      for (int i = 0; i < k; i++) step(1'b0, 16'h0, 4'h0, e);
   endtask

   task automatic align(input int target, input logic [3:0] e);
      while (pos % FRAME != target) step(1'b0, 16'h0, 4'h0, e);
   endtask

   task automatic check_reset_outputs(input string tag);
      n_cmp++;
      if (digitselect !== 4'hF) begin
         n_fail++;
         $display("FAIL %s digitselect got %b want 1111", tag, digitselect);
      end
      n_cmp++;
      if (segments !== 8'hFF) begin
         n_fail++;
         $display("FAIL %s segments got %h want ff", tag, segments);
      end
      n_cmp++;
      if (frame_done !== 1'b0) begin
         n_fail++;
         $display("FAIL %s frame_done got %b want 0", tag, frame_done);
      end
      n_cmp++;
      if (pending !== 1'b0) begin
         n_fail++;
         $display("FAIL %s pending got %b want 0", tag, pending);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset_hold");
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic test_idle_scan();
      run(40, 4'hF);
   endtask

   task automatic test_load_midframe();
      align(5, 4'hF);
      step(1'b1, 16'h1A3F, 4'h0, 4'hF);
      run(36, 4'hF);
   endtask

   task automatic test_last_load_wins();
      align(2, 4'hF);
      step(1'b1, 16'h1111, 4'h0, 4'hF);
      run(3, 4'hF);
      step(1'b1, 16'h2222, 4'h0, 4'hF);
      run(40, 4'hF);
   endtask

   task automatic test_enable_dp();
      step(1'b1, 16'h8421, 4'b0010, 4'b1010);
      run(40, 4'b1010);
   endtask

   task automatic test_leading_zero();
      step(1'b1, 16'h0050, 4'h0, 4'hF);
      run(40, 4'hF);
   endtask

   task automatic test_boundary_load();
      align(FRAME - 1, 4'hF);
      step(1'b1, 16'hBE0F, 4'b0101, 4'hF);
      run(20, 4'hF);
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 7) == 0, 16'($urandom), 4'($urandom), 4'($urandom));
   endtask

   task automatic test_reset_midframe();
      align(8, 4'hF);
      step(1'b1, 16'hC0DE, 4'h3, 4'hF);
      step(1'b0, 16'h0, 4'h0, 4'hF);
      n_cmp++;
      if (pending !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_pending got %b want 1", pending);
      end
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midframe_reset");
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      run(20, 4'hF);
   endtask

   initial begin
      test_reset();
      test_idle_scan();
      test_load_midframe();
      test_last_load_wins();
      test_enable_dp();
      test_leading_zero();
      test_boundary_load();
      test_random();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
